fp_mul_norm_round: RTL and testbench
====================================

Name: fp_mul_norm_round

Overview:
- Post-multiply stage of the FP multiplier datapath, directly downstream of the significand multiplier.
- Consumes the full 2(N+1)-bit significand product (hidden bits included), the pre-normalization exponent and the result sign.
- Normalizes, rounds to nearest-even, and detects overflow and underflow; packs an IEEE-style {sign, exp, frac} word.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- N, 23, fraction width (hidden bit excluded); product input is 2*(N+1) bits.
- E, 8, exponent field width; bias is 2^(E-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept input.
- prod  in  2N+2  significand product, value in [1,4).
- exp_in  in  E+2  signed two's-complement biased exponent before normalization (ea+eb-bias).
- sign_in  in  1  result sign.
- zero_in  in  1  either operand zero; forces signed-zero result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  1+E+N  {sign, exp, frac}.
- ovf  out  1  overflow flag for current result.
- unf  out  1  underflow (flush) flag for current result.
- inexact  out  1  rounding or flush lost nonzero bits.
- sts  out  3  sticky {ovf, unf, inexact} status (optional feature).
- sts_clr  in  1  clear sticky status (optional feature).

Behaviour:
- Reset (rst=0, async): both stage valids=0, out_valid=0, result=0, ovf=unf=inexact=0, sts=0. In-flight beats are discarded; in_ready=1 after release.
- Handshake: a beat transfers on valid&&ready. Each stage advances when its successor is empty or advancing. in_ready = !s1_valid || s1_adv, so it is combinational from out_ready.
- Full throughput. Latency is 2 cycles from input accept to out_valid when out_ready=1. Beat order is preserved.
- While out_valid && !out_ready, result and flags hold stable.
- Stage 1, normalize:
  - If prod[2N+1]=1: frac=prod[2N:N+1], G=prod[N], S=|prod[N-1:0], exp=exp_in+1.
  - Otherwise: frac=prod[2N-1:N], G=prod[N-1], S=|prod[N-2:0], exp=exp_in.
  - Register sign, zero, frac, G, S and exp (E+2 bits signed).
- Stage 2, round (RNE):
  - Round up when G && (S || frac[0]); inexact = G||S.
  - If frac is all ones and rounds up: frac=0, exp+1.
- Range check (after rounding):
  - exp >= 2^E-1: result = {sign, all-ones, 0} (infinity); ovf=1, inexact=1.
  - exp <= 0: result = {sign, 0, 0} (no subnormals, flush); unf=1, inexact=1.
  - zero_in=1 overrides everything: {sign, 0, 0}, all flags 0.
- Flags are per-result and registered with result.
- exp arithmetic is E+2 bits signed; no wrap for exp_in in [-(2^E), 2^(E+1)-2].

Optional Feature:
- Macro FP_NR_STATUS_EN.
- Defined:
  - sts[2:0] ORs in {ovf, unf, inexact} of each beat on the cycle it transfers out (out_valid&&out_ready).
  - sts_clr=1 clears sts synchronously. Clear wins over a simultaneous set. Reset clears sts.
- Undefined: sts tied to 0; sts_clr ignored. Ports remain present.

Test Plan:
- 1.5x1.5: prod=0x900000000000, exp_in=127, sign 0, out_ready=1 -> result 0x40100000 two cycles after accept; flags 0.
- RNE tie: prod=0x400000400000, exp_in=127 -> 0x3F800000 (tie to even), inexact=1. Then prod=0x400000C00000 -> 0x3F800002, inexact=1.
- Round carry: prod=0x7FFFFFC00000, exp_in=127 -> 0x40000000, inexact=1.
- Range:
  - exp_in=254, prod=0x900000000000, sign 1 -> 0xFF800000, ovf=1.
  - exp_in=0, prod=0x400000000000 -> 0x00000000, unf=1.
  - zero_in=1 with sign 1 -> 0x80000000, flags 0.
- Backpressure:
  - Setup: out_ready=0 for 4 cycles while offering 3 beats.
  - Required: exactly 2 accepted, in_ready=0 on 3rd, output stable.
  - Release: out_ready=1 -> 3 results in input order, no loss or duplication.
- Reset mid-stream, with FP_NR_STATUS_EN defined:
  - Assert rst with 2 beats in flight -> out_valid=0 immediately, no stale result after release.
  - An ovf beat sets sts=3'b101; sts_clr pulse -> 0.

Source files
------------

// File: rtl/fp_mul_norm_round.sv
// Post-multiply normalize / round-to-nearest-even / range-check stage, two-stage valid/ready pipeline.
// Optional sticky status register enabled by defining FP_NR_STATUS_EN.
module fp_mul_norm_round #(
  parameter int N = 23,
  parameter int E = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N+1:0]   prod,
  input  logic [E+1:0]     exp_in,
  input  logic             sign_in,
  input  logic             zero_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+N:0]     result,
  output logic             ovf,
  output logic             unf,
  output logic             inexact,
  output logic [2:0]       sts,
  input  logic             sts_clr
);

  // One extra bit over the stage exponent so the rounding carry can never wrap.
  localparam int XW = E + 3;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** E) - 1);

  logic                s1_valid_r;
  logic                s1_sign_r;
  logic                s1_zero_r;
  logic [N-1:0]        s1_frac_r;
  logic                s1_g_r;
  logic                s1_s_r;
  logic [E+1:0]        s1_exp_r;

  logic [N-1:0]        nrm_frac_s;
  logic                nrm_g_s;
  logic                nrm_s_s;
  logic [E+1:0]        nrm_exp_s;

  logic                rnd_up_s;
  logic [N:0]          frac_sum_s;
  logic signed [XW-1:0] exp_rnd_s;
  logic [E+N:0]        res_s;
  logic [2:0]          flg_s;
  logic                s2_take_s;

  assign s2_take_s = !out_valid || out_ready;
  assign in_ready  = !s1_valid_r || s2_take_s;

  // Stage-1 normalization: select the fraction window by the product's leading bit.
  always_comb begin
    if (prod[2*N+1]) begin
      nrm_frac_s = prod[2*N:N+1];
      nrm_g_s    = prod[N];
      nrm_s_s    = |prod[N-1:0];
      nrm_exp_s  = exp_in + (E+2)'(1);
    end else begin
      nrm_frac_s = prod[2*N-1:N];
      nrm_g_s    = prod[N-1];
      nrm_s_s    = |prod[N-2:0];
      nrm_exp_s  = exp_in;
    end
  end

  // Stage-1 register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_frac_r  <= '0;
      s1_g_r     <= 1'b0;
      s1_s_r     <= 1'b0;
      s1_exp_r   <= '0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r <= sign_in;
        s1_zero_r <= zero_in;
        s1_frac_r <= nrm_frac_s;
        s1_g_r    <= nrm_g_s;
        s1_s_r    <= nrm_s_s;
        s1_exp_r  <= nrm_exp_s;
      end
    end
  end

  // Stage-2 RNE rounding, carry into exponent, then overflow/underflow/zero packing.
  always_comb begin
    rnd_up_s   = s1_g_r && (s1_s_r || s1_frac_r[0]);
    frac_sum_s = {1'b0, s1_frac_r} + {{N{1'b0}}, rnd_up_s};
    exp_rnd_s  = $signed({s1_exp_r[E+1], s1_exp_r}) + $signed({{(XW-1){1'b0}}, frac_sum_s[N]});
    if (s1_zero_r) begin
      res_s = {s1_sign_r, {E{1'b0}}, {N{1'b0}}};
      flg_s = 3'b000;
    end else if (exp_rnd_s >= EXP_MAX) begin
      res_s = {s1_sign_r, {E{1'b1}}, {N{1'b0}}};
      flg_s = 3'b101;
    end else if (exp_rnd_s <= $signed({XW{1'b0}})) begin
      res_s = {s1_sign_r, {E{1'b0}}, {N{1'b0}}};
      flg_s = 3'b011;
    end else begin
      res_s = {s1_sign_r, exp_rnd_s[E-1:0], frac_sum_s[N-1:0]};
      flg_s = {2'b00, s1_g_r || s1_s_r};
    end
  end

  // Stage-2 output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inexact   <= 1'b0;
    end else if (s2_take_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        result  <= res_s;
        ovf     <= flg_s[2];
        unf     <= flg_s[1];
        inexact <= flg_s[0];
      end
    end
  end

`ifdef FP_NR_STATUS_EN
  logic [2:0] sts_r;

  // Sticky status: accumulate flags of each delivered beat; clear beats set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sts_r <= 3'b000;
    end else if (sts_clr) begin
      sts_r <= 3'b000;
    end else if (out_valid && out_ready) begin
      sts_r <= sts_r | {ovf, unf, inexact};
    end
  end

  assign sts = sts_r;
`else
  logic unused_sts_clr;
  assign unused_sts_clr = sts_clr;
  assign sts = 3'b000;
`endif

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: rounding, range, backpressure, reset and sticky status.
module tb_fp_mul_norm_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] prod;
  logic [9:0]  exp_in;
  logic        sign_in;
  logic        zero_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        inexact;
  logic [2:0]  sts;
  logic        sts_clr;

  int checks;
  int errors;

`ifdef FP_NR_STATUS_EN
  localparam logic [2:0] STS_AFTER_OVF = 3'b101;
`else
  localparam logic [2:0] STS_AFTER_OVF = 3'b000;
`endif

  logic [47:0] bp_prod [3];
  logic [31:0] bp_res  [3];

  fp_mul_norm_round #(.N(23), .E(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .exp_in(exp_in), .sign_in(sign_in), .zero_in(zero_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf), .inexact(inexact),
    .sts(sts), .sts_clr(sts_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Single beat with out_ready=1: accepted now, out_valid exactly two cycles later.
  task automatic run_vec(input string tag, input logic [47:0] p, input logic [9:0] e,
                         input logic s, input logic z, input logic [31:0] r, input logic [2:0] fl);
    prod = p; exp_in = e; sign_in = s; zero_in = z; in_valid = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, result, r);
    chk({tag, "_flg"}, {ovf, unf, inexact}, fl);
    @(negedge clk);
  endtask

  task automatic apply_bp(input int i);
    prod = bp_prod[i]; exp_in = 10'd127; sign_in = 1'b0; zero_in = 1'b0; in_valid = 1'b1;
  endtask

  initial begin
    int idx;
    int acc;
    int outcnt;
    logic xfer_in;
    logic xfer_out;

    clk = 1'b0; rst = 1'b0; in_valid = 1'b0; prod = '0; exp_in = '0;
    sign_in = 1'b0; zero_in = 1'b0; out_ready = 1'b1; sts_clr = 1'b0;
    checks = 0; errors = 0;
    bp_prod[0] = 48'h900000000000; bp_res[0] = 32'h40100000;
    bp_prod[1] = 48'h400000400000; bp_res[1] = 32'h3F800000;
    bp_prod[2] = 48'h400000C00000; bp_res[2] = 32'h3F800002;

    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flg", {ovf, unf, inexact}, 0);
    chk("rst_sts", sts, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);

    run_vec("mul15", 48'h900000000000, 10'd127, 1'b0, 1'b0, 32'h40100000, 3'b000);
    run_vec("tie_even", 48'h400000400000, 10'd127, 1'b0, 1'b0, 32'h3F800000, 3'b001);
    run_vec("tie_up", 48'h400000C00000, 10'd127, 1'b0, 1'b0, 32'h3F800002, 3'b001);
    run_vec("carry", 48'h7FFFFFC00000, 10'd127, 1'b0, 1'b0, 32'h40000000, 3'b001);
    run_vec("ovf", 48'h900000000000, 10'd254, 1'b1, 1'b0, 32'hFF800000, 3'b101);
    run_vec("unf", 48'h400000000000, 10'd0, 1'b0, 1'b0, 32'h00000000, 3'b011);
    run_vec("zero", 48'h900000000000, 10'd127, 1'b1, 1'b1, 32'h80000000, 3'b000);

    // Backpressure: consumer stalled for 4 cycles while 3 beats are offered.
    out_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 3) apply_bp(idx);
      else in_valid = 1'b0;
      xfer_in = in_valid && in_ready;
      if (xfer_in) acc++;
      if (c == 3) chk("bp_hold0", result, bp_res[0]);
      @(negedge clk);
      if (xfer_in) idx++;
    end
    chk("bp_acc", acc, 2);
    chk("bp_rdy3", in_ready, 0);
    chk("bp_vld", out_valid, 1);
    chk("bp_hold1", result, bp_res[0]);

    out_ready = 1'b1; outcnt = 0;
    for (int c = 0; c < 20 && outcnt < 3; c++) begin
      xfer_out = out_valid;
      xfer_in  = in_valid && in_ready;
      if (xfer_out) begin
        chk($sformatf("bp_out%0d", outcnt), result, bp_res[outcnt]);
        outcnt++;
      end
      @(negedge clk);
      if (xfer_in) idx++;
      if (idx < 3) apply_bp(idx);
      else in_valid = 1'b0;
    end
    chk("bp_cnt", outcnt, 3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_nodup", out_valid, 0);

    // Reset with two beats in flight.
    apply_bp(0);
    @(negedge clk);
    apply_bp(1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_pre", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_vld", out_valid, 0);
    chk("mid_rdy", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_stale", out_valid, 0);
    end
    chk("mid_sts", sts, 0);

    // Sticky status from an overflow beat, then clear.
    run_vec("sts_ovf", 48'h900000000000, 10'd254, 1'b1, 1'b0, 32'hFF800000, 3'b101);
    chk("sts_set", sts, STS_AFTER_OVF);
    sts_clr = 1'b1;
    @(negedge clk);
    sts_clr = 1'b0;
    chk("sts_clr", sts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
